ad4003_acq_scheduler: RTL and testbench
=======================================

// Module: ad4003_acq_scheduler
// PURPOSE
//  Sequences the AD4003 3-wire turbo-mode conversion generator. Issues one-cycle conversion
//  triggers at a programmable sample period and handshakes each trigger against the
//  generator's data-valid pulse. Counts samples for finite bursts or runs continuously.
//  Flags overrun (period shorter than conversion+readout) and lost-handshake timeouts.
//  Sits between the PS-side control registers and the conversion generator's trigger input.
// PARAMETERS
//  PERIOD_MIN      60    minimum trigger spacing in clk cycles; smaller i_period is clamped to it
//  TIMEOUT_CYCLES  1200  clk cycles allowed from o_trig to i_dv before a timeout abort
//  CNT_W           16    width of burst length and sample counter
// PORTS
//  clk             in   1      system clock (200 MHz nominal)
//  rst_L           in   1      synchronous active-low reset
//  i_enable        in   1      level: 1 = run acquisition, 0 = stop after current sample
//  i_abort         in   1      pulse: stop immediately
//  i_period        in   32     trigger spacing in clk cycles; latched at start
//  i_burst_len     in   CNT_W  samples per burst, 0 = continuous; latched at start
//  i_dv            in   1      one-cycle data-valid pulse from the conversion generator
//  o_trig          out  1      one-cycle conversion trigger to the conversion generator
//  o_busy          out  1      1 while in any state other than IDLE
//  o_done          out  1      one-cycle pulse when a burst or stopped run completes normally
//  o_overrun       out  1      sticky: a period elapsed before i_dv arrived
//  o_timeout       out  1      sticky: i_dv missing for TIMEOUT_CYCLES
//  o_sample_count  out  CNT_W  samples completed in the current or last run
//  o_debug_state   out  3      current state encoding
// BEHAVIOUR
//  Reset (rst_L=0 at posedge clk): state IDLE; all outputs 0; counters and latched values 0.
//  States: IDLE=0, FIRE=1, WAIT_DV=2, WAIT_PERIOD=3, DONE=4.
//  IDLE: when i_enable=1 -> latch period=max(i_period,PERIOD_MIN) and burst=i_burst_len;
//   clear o_sample_count, o_overrun and o_timeout; -> FIRE.
//  FIRE: o_trig=1 for exactly this cycle; period counter and timeout counter cleared to 0; -> WAIT_DV.
//  Period counter: increments every cycle after FIRE, saturates at period-1.
//  WAIT_DV: on i_dv: o_sample_count+1. Then:
//   burst!=0 and new count==burst -> DONE; i_enable=0 -> DONE;
//   period counter already at period-1 -> FIRE (late trigger); else -> WAIT_PERIOD.
//   Period counter reaching period-1 while still in WAIT_DV sets o_overrun (sticky).
//   Timeout counter reaching TIMEOUT_CYCLES-1 with no i_dv -> set o_timeout, -> IDLE, no o_done.
//   i_dv and timeout in the same cycle: i_dv wins.
//  WAIT_PERIOD: i_enable=0 -> DONE. Otherwise, when period counter==period-1 -> FIRE, so
//   o_trig pulses are exactly `period` cycles apart when no overrun occurs.
//  DONE: o_done=1 for this cycle; -> IDLE. A re-start needs i_enable seen high in IDLE.
//  i_abort=1 in any non-IDLE state: -> IDLE next cycle; no o_trig, no o_done; count not
//   incremented, even if i_dv coincides. Sticky flags are held.
//  i_dv outside WAIT_DV: ignored. i_period/i_burst_len changes mid-run: ignored until next start.
//  o_sample_count wraps modulo 2^CNT_W in continuous mode. o_busy=(state!=IDLE).
//  rst_L low mid-run: all state cleared; no o_trig or o_done is emitted.
// TESTING
//  period=100, burst=4, i_dv 50 cycles after each o_trig -> o_trig at t0,t0+100,t0+200,t0+300;
//   o_done 2 cycles after 4th i_dv; count=4; no flags set.
//  i_period=10 -> spacing clamps to 60 cycles between o_trig pulses.
//  period=60, i_dv 80 cycles after o_trig -> o_overrun=1; next o_trig 2 cycles after i_dv.
//  No i_dv after o_trig -> o_timeout=1 at trig+TIMEOUT_CYCLES; state IDLE; o_done stays 0.
//  burst=0, drop i_enable in WAIT_PERIOD -> DONE then IDLE; i_abort in WAIT_DV together with
//   i_dv -> IDLE; count unchanged; no o_done.
//  rst_L=0 for 1 cycle mid-burst -> all outputs 0 next cycle; no spurious o_trig afterwards.

Source files
------------

// File: rtl/ad4003_acq_scheduler.sv
// ----------------------------------------------------------------------------
// ad4003_acq_scheduler
// Paces conversion triggers for the AD4003 turbo-mode conversion generator.
// Each trigger is handshaken against the generator's data-valid pulse. The
// block runs finite bursts or continuously, and it raises sticky flags when a
// period elapses before the data arrives (overrun) or when the data never
// arrives (timeout).
//
// All outputs come straight from flops. o_trig, o_done and o_busy are loaded
// from the next-state decode, so they line up exactly with the state register.
// The incoming data-valid pulse is registered before it is used. As a result a
// decision taken on i_dv becomes visible two cycles after the i_dv cycle.
// ----------------------------------------------------------------------------
module ad4003_acq_scheduler #(
    parameter int PERIOD_MIN     = 60,
    parameter int TIMEOUT_CYCLES = 1200,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             i_enable,
    input  logic             i_abort,
    input  logic [31:0]      i_period,
    input  logic [CNT_W-1:0] i_burst_len,
    input  logic             i_dv,
    output logic             o_trig,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overrun,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_sample_count,
    output logic [2:0]       o_debug_state
);

    // State encodings are visible on o_debug_state, so they are fixed values.
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_FIRE        = 3'd1;
    localparam logic [2:0] ST_WAIT_DV     = 3'd2;
    localparam logic [2:0] ST_WAIT_PERIOD = 3'd3;
    localparam logic [2:0] ST_DONE        = 3'd4;

    localparam logic [31:0]      PERIOD_MIN_W = 32'(PERIOD_MIN);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

    // Registers
    logic [2:0]       state_r;
    logic [31:0]      period_r;
    logic [CNT_W-1:0] burst_r;
    logic [31:0]      pcnt_r;
    logic [31:0]      tcnt_r;
    logic             dv_r;
    logic [CNT_W-1:0] count_r;
    logic             overrun_r;
    logic             timeout_r;
    logic             trig_r;
    logic             done_r;
    logic             busy_r;

    // Combinational decode
    logic [2:0]       state_s;
    logic [CNT_W-1:0] count_inc_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [31:0]      period_last_val_s;
    logic             period_last_s;
    logic             timeout_last_s;
    logic             start_s;
    logic             overrun_set_s;
    logic             timeout_set_s;

    assign count_inc_s       = count_r + CNT_ONE;
    assign period_last_val_s = period_r - 32'd1;
    assign period_last_s     = (pcnt_r == period_last_val_s);
    assign timeout_last_s    = (tcnt_r == TIMEOUT_LAST);

    // Overrun means the period ran out while the current sample was still outstanding.
    assign overrun_set_s = (state_r == ST_WAIT_DV) && !i_abort && !dv_r && period_last_s;

    // Next-state, sample-count and timeout decisions
    always_comb begin
        state_s       = state_r;
        count_nxt_s   = count_r;
        start_s       = 1'b0;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_enable) begin
                    start_s     = 1'b1;
                    count_nxt_s = CNT_ZERO;
                    state_s     = ST_FIRE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DV;
                end
            end
            ST_WAIT_DV: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else if (dv_r) begin
                    // A sample that arrives on the timeout cycle still counts.
                    count_nxt_s = count_inc_s;
                    if ((burst_r != CNT_ZERO) && (count_inc_s == burst_r)) begin
                        state_s = ST_DONE;
                    end else if (!i_enable) begin
                        state_s = ST_DONE;
                    end else if (period_last_s) begin
                        state_s = ST_FIRE;
                    end else begin
                        state_s = ST_WAIT_PERIOD;
                    end
                end else if (timeout_last_s) begin
                    timeout_set_s = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DV;
                end
            end
            ST_WAIT_PERIOD: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else if (!i_enable) begin
                    state_s = ST_DONE;
                end else if (period_last_s) begin
                    state_s = ST_FIRE;
                end else begin
                    state_s = ST_WAIT_PERIOD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                // An illegal encoding falls back to IDLE.
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched run parameters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_r   <= ST_IDLE;
            period_r  <= 32'd0;
            burst_r   <= CNT_ZERO;
            pcnt_r    <= 32'd0;
            tcnt_r    <= 32'd0;
            dv_r      <= 1'b0;
            count_r   <= CNT_ZERO;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
            trig_r    <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_nxt_s;

            // The run parameters are captured only when a run starts.
            if (start_s) begin
                period_r <= (i_period < PERIOD_MIN_W) ? PERIOD_MIN_W : i_period;
                burst_r  <= i_burst_len;
            end

            // The period counter is 0 on the trigger cycle, so triggers are
            // exactly `period` cycles apart. It holds at period-1.
            if (state_s == ST_FIRE) begin
                pcnt_r <= 32'd0;
            end else if ((state_r != ST_IDLE) && !period_last_s) begin
                pcnt_r <= pcnt_r + 32'd1;
            end

            // The timeout counter measures the time since the last trigger.
            if (state_s == ST_FIRE) begin
                tcnt_r <= 32'd0;
            end else if ((state_r != ST_IDLE) && !timeout_last_s) begin
                tcnt_r <= tcnt_r + 32'd1;
            end

            // A data-valid pulse is kept only if it arrives while waiting and no abort is pending.
            dv_r <= i_dv && (state_r == ST_WAIT_DV) && !i_abort;

            if (start_s) begin
                overrun_r <= 1'b0;
            end else if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end

            if (start_s) begin
                timeout_r <= 1'b0;
            end else if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end

            trig_r <= (state_s == ST_FIRE);
            done_r <= (state_s == ST_DONE);
            busy_r <= (state_s != ST_IDLE);
        end
    end

    assign o_trig         = trig_r;
    assign o_busy         = busy_r;
    assign o_done         = done_r;
    assign o_overrun      = overrun_r;
    assign o_timeout      = timeout_r;
    assign o_sample_count = count_r;
    assign o_debug_state  = state_r;

endmodule

// File: tb/tb_ad4003_acq_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ad4003_acq_scheduler
// Directed bench for the acquisition scheduler. Inputs are driven and outputs
// are sampled 1 ns after each rising clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad4003_acq_scheduler;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_L;
    logic             i_enable;
    logic             i_abort;
    logic [31:0]      i_period;
    logic [CNT_W-1:0] i_burst_len;
    logic             i_dv;
    logic             o_trig;
    logic             o_busy;
    logic             o_done;
    logic             o_overrun;
    logic             o_timeout;
    logic [CNT_W-1:0] o_sample_count;
    logic [2:0]       o_debug_state;

    int n_cmp = 0;
    int n_err = 0;

    ad4003_acq_scheduler #(
        .PERIOD_MIN    (60),
        .TIMEOUT_CYCLES(1200),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_L         (rst_L),
        .i_enable      (i_enable),
        .i_abort       (i_abort),
        .i_period      (i_period),
        .i_burst_len   (i_burst_len),
        .i_dv          (i_dv),
        .o_trig        (o_trig),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overrun     (o_overrun),
        .o_timeout     (o_timeout),
        .o_sample_count(o_sample_count),
        .o_debug_state (o_debug_state)
    );

    // 100 MHz bench clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence hangs
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advances until o_trig is seen or the limit expires; n is the number of ticks taken.
    task automatic wait_trig(input int limit, output int n);
        n = 0;
        while (o_trig !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Current position is just after the trigger edge. i_dv is driven high
    // k cycles later; the task returns one edge after the i_dv cycle.
    task automatic pulse_dv(input int k);
        repeat (k) tick();
        i_dv = 1'b1;
        tick();
        i_dv = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;

        rst_L       = 1'b0;
        i_enable    = 1'b0;
        i_abort     = 1'b0;
        i_period    = 32'd0;
        i_burst_len = 16'd0;
        i_dv        = 1'b0;
        repeat (3) tick();
        rst_L = 1'b1;
        tick();

        // Reset state
        chk("rst_trig",    32'(o_trig), 32'd0);
        chk("rst_busy",    32'(o_busy), 32'd0);
        chk("rst_done",    32'(o_done), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_count",   32'(o_sample_count), 32'd0);
        chk("rst_state",   32'(o_debug_state), 32'd0);

        // i_dv in IDLE is ignored
        pulse_dv(0);
        tick();
        chk("idle_dv_ignored", 32'(o_sample_count), 32'd0);

        // Burst of 4 at period 100, i_dv 50 cycles after each trigger
        i_period    = 32'd100;
        i_burst_len = 16'd4;
        i_enable    = 1'b1;
        tick();
        chk("b_trig0",  32'(o_trig), 32'd1);
        chk("b_state0", 32'(o_debug_state), 32'd1);
        chk("b_busy0",  32'(o_busy), 32'd1);
        i_period    = 32'd500;   // mid-run changes must be ignored
        i_burst_len = 16'd7;
        pulse_dv(50);
        for (int s = 1; s < 4; s++) begin
            wait_trig(200, n);
            chk("b_spacing", 32'(n), 32'd49);
            chk("b_count",   32'(o_sample_count), 32'(s));
            pulse_dv(50);
        end
        tick();
        chk("b_done",    32'(o_done), 32'd1);
        chk("b_state_d", 32'(o_debug_state), 32'd4);
        chk("b_count4",  32'(o_sample_count), 32'd4);
        chk("b_overrun", 32'(o_overrun), 32'd0);
        chk("b_timeout", 32'(o_timeout), 32'd0);
        i_enable = 1'b0;
        tick();
        chk("b_idle_busy", 32'(o_busy), 32'd0);
        chk("b_idle_done", 32'(o_done), 32'd0);
        chk("b_hold_cnt",  32'(o_sample_count), 32'd4);

        // Period below the minimum clamps to 60
        i_period    = 32'd10;
        i_burst_len = 16'd2;
        i_enable    = 1'b1;
        tick();
        chk("c_trig0", 32'(o_trig), 32'd1);
        chk("c_count_cleared", 32'(o_sample_count), 32'd0);
        pulse_dv(5);
        wait_trig(200, n);
        chk("c_spacing", 32'(n), 32'd54);
        pulse_dv(5);
        tick();
        chk("c_done",  32'(o_done), 32'd1);
        chk("c_count", 32'(o_sample_count), 32'd2);
        i_enable = 1'b0;
        tick();

        // Overrun: period 60, i_dv 80 cycles after trigger
        i_period    = 32'd60;
        i_burst_len = 16'd2;
        i_enable    = 1'b1;
        tick();
        chk("o_trig0", 32'(o_trig), 32'd1);
        pulse_dv(80);
        chk("o_overrun_set", 32'(o_overrun), 32'd1);
        chk("o_no_trig_yet", 32'(o_trig), 32'd0);
        tick();
        chk("o_late_trig", 32'(o_trig), 32'd1);
        chk("o_count1",    32'(o_sample_count), 32'd1);
        pulse_dv(20);
        tick();
        chk("o_done",        32'(o_done), 32'd1);
        chk("o_overrun_hold",32'(o_overrun), 32'd1);
        i_enable = 1'b0;
        tick();

        // Timeout: no i_dv after trigger
        i_period    = 32'd100;
        i_burst_len = 16'd0;
        i_enable    = 1'b1;
        tick();
        chk("t_trig0",        32'(o_trig), 32'd1);
        chk("t_overrun_clr",  32'(o_overrun), 32'd0);
        repeat (1199) tick();
        chk("t_not_yet", 32'(o_timeout), 32'd0);
        chk("t_busy",    32'(o_busy), 32'd1);
        i_enable = 1'b0;
        tick();
        chk("t_timeout",  32'(o_timeout), 32'd1);
        chk("t_state",    32'(o_debug_state), 32'd0);
        chk("t_done",     32'(o_done), 32'd0);
        chk("t_overrun",  32'(o_overrun), 32'd1);
        tick();
        chk("t_done_after", 32'(o_done), 32'd0);
        chk("t_sticky",     32'(o_timeout), 32'd1);

        // Continuous run stopped in WAIT_PERIOD
        i_period    = 32'd60;
        i_burst_len = 16'd0;
        i_enable    = 1'b1;
        tick();
        chk("s_timeout_clr", 32'(o_timeout), 32'd0);
        pulse_dv(10);
        tick();
        chk("s_wait_period", 32'(o_debug_state), 32'd3);
        i_enable = 1'b0;
        tick();
        chk("s_done",  32'(o_done), 32'd1);
        chk("s_state", 32'(o_debug_state), 32'd4);
        chk("s_count", 32'(o_sample_count), 32'd1);
        tick();
        chk("s_idle", 32'(o_busy), 32'd0);

        // Abort together with i_dv in WAIT_DV
        i_enable = 1'b1;
        tick();
        chk("a_trig0", 32'(o_trig), 32'd1);
        repeat (5) tick();
        chk("a_wait_dv", 32'(o_debug_state), 32'd2);
        i_dv    = 1'b1;
        i_abort = 1'b1;
        tick();
        i_dv     = 1'b0;
        i_abort  = 1'b0;
        i_enable = 1'b0;
        chk("a_state", 32'(o_debug_state), 32'd0);
        chk("a_done",  32'(o_done), 32'd0);
        chk("a_count", 32'(o_sample_count), 32'd0);
        tick();
        chk("a_count_after", 32'(o_sample_count), 32'd0);
        chk("a_done_after",  32'(o_done), 32'd0);

        // Reset mid-burst
        i_period    = 32'd100;
        i_burst_len = 16'd4;
        i_enable    = 1'b1;
        tick();
        pulse_dv(20);
        repeat (3) tick();
        chk("r_count1", 32'(o_sample_count), 32'd1);
        rst_L    = 1'b0;
        i_enable = 1'b0;
        tick();
        rst_L = 1'b1;
        chk("r_trig",  32'(o_trig), 32'd0);
        chk("r_busy",  32'(o_busy), 32'd0);
        chk("r_count", 32'(o_sample_count), 32'd0);
        chk("r_state", 32'(o_debug_state), 32'd0);
        chk("r_done",  32'(o_done), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (o_trig === 1'b1 || o_done === 1'b1) seen = 1'b1;
        end
        chk("r_no_spurious", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
